// File: rtl/pwm_buffer_multi.sv
// pwm_buffer_multi: double-buffered, multi-channel PWM rise/fall register bank.
// Rise/fall values are written per channel into a shadow bank, then a COMMIT
// moves every shadow entry into the active bank, either at each channel's own
// PWM cycle boundary (MODE=0) or all at once on the COMMIT edge (MODE=1).
// Active values are clamped to the channel's period so a generator never sees
// an edge position beyond its own cycle.
module pwm_buffer_multi #(
    parameter int WIDTH  = 13,
    parameter int NUM_CH = 249,
    parameter int ADDR_W = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    MODE,
    input  logic [NUM_CH*WIDTH-1:0] CYCLE_M1,
    input  logic [NUM_CH*WIDTH-1:0] TIME_CNT,
    input  logic                    WR_EN,
    input  logic [ADDR_W-1:0]       WR_ADDR,
    input  logic [WIDTH-1:0]        WR_RISE,
    input  logic [WIDTH-1:0]        WR_FALL,
    input  logic                    COMMIT,
    output logic [NUM_CH*WIDTH-1:0] RISE_OUT,
    output logic [NUM_CH*WIDTH-1:0] FALL_OUT,
    output logic                    BUSY,
    output logic                    UPDATE_DONE
);

    typedef logic [WIDTH-1:0] val_t;

    val_t              shadow_rise_q [NUM_CH];
    val_t              shadow_rise_d [NUM_CH];
    val_t              shadow_fall_q [NUM_CH];
    val_t              shadow_fall_d [NUM_CH];
    val_t              active_rise_q [NUM_CH];
    val_t              active_rise_d [NUM_CH];
    val_t              active_fall_q [NUM_CH];
    val_t              active_fall_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic              done_q;
    logic              done_d;

    logic [NUM_CH-1:0] at_boundary;
    logic              commit_sync;
    logic              commit_imm;

    // Limit a value to the channel's last count (unsigned compare).
    function automatic val_t clamp(input val_t v, input val_t lim);
        return (v > lim) ? lim : v;
    endfunction

    // MODE only matters on the COMMIT edge itself.
    assign commit_sync = COMMIT & ~MODE;
    assign commit_imm  = COMMIT &  MODE;

    // Per-channel end-of-period detect: the edge where a sync transfer may land.
    always_comb begin
        at_boundary = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            at_boundary[i] = (TIME_CNT[i*WIDTH +: WIDTH] == CYCLE_M1[i*WIDTH +: WIDTH]);
        end
    end

    // Next-state: shadow writes, shadow-to-active transfers, pending and done tracking.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so any path that does not
        // touch a signal simply holds it; without these defaults synthesis infers latches.
        shadow_rise_d = shadow_rise_q;
        shadow_fall_d = shadow_fall_q;
        active_rise_d = active_rise_q;
        active_fall_d = active_fall_q;
        pending_d     = pending_q;

        for (int i = 0; i < NUM_CH; i++) begin
            // Transfers read shadow_*_q, so a same-edge write only reaches the shadow.
            if (commit_imm || (pending_q[i] && at_boundary[i])) begin
                active_rise_d[i] = clamp(shadow_rise_q[i], CYCLE_M1[i*WIDTH +: WIDTH]);
                active_fall_d[i] = clamp(shadow_fall_q[i], CYCLE_M1[i*WIDTH +: WIDTH]);
            end

            // A sync COMMIT re-arms every channel, even one sitting at its boundary now.
            if (commit_sync) begin
                pending_d[i] = 1'b1;
            end else if (commit_imm) begin
                pending_d[i] = 1'b0;
            end else if (pending_q[i] && at_boundary[i]) begin
                pending_d[i] = 1'b0;
            end

            // Addresses at or above NUM_CH match no channel and are dropped.
            if (WR_EN && (WR_ADDR == ADDR_W'(i))) begin
                shadow_rise_d[i] = WR_RISE;
                shadow_fall_d[i] = WR_FALL;
            end
        end

        // Only a boundary-driven drain of the last pending bit signals completion.
        done_d = (|pending_q) && !(|pending_d) && !commit_imm;
    end

    // State registers for both banks plus the commit handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the shadow and active banks are visible behaviour after reset
            // (outputs and later commits read them), so each entry is cleared here
            // rather than left to power-up contents.
            shadow_rise_q <= '{default: '0};
            shadow_fall_q <= '{default: '0};
            active_rise_q <= '{default: '0};
            active_fall_q <= '{default: '0};
            pending_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values computed above, independent of statement order.
            shadow_rise_q <= shadow_rise_d;
            shadow_fall_q <= shadow_fall_d;
            active_rise_q <= active_rise_d;
            active_fall_q <= active_fall_d;
            pending_q     <= pending_d;
            done_q        <= done_d;
        end
    end

    // Pack the active bank onto the flat output buses.
    always_comb begin
        RISE_OUT = '0;
        FALL_OUT = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            RISE_OUT[i*WIDTH +: WIDTH] = active_rise_q[i];
            FALL_OUT[i*WIDTH +: WIDTH] = active_fall_q[i];
        end
    end

    assign BUSY        = |pending_q;
    assign UPDATE_DONE = done_q;

endmodule

// File: tb/tb_pwm_buffer_multi.sv
// tb_pwm_buffer_multi: directed bench for pwm_buffer_multi with a 4-channel build.
// Each commit pushes the expected transfers (channel, due edge, clamped values)
// onto a scoreboard queue; every cycle the due entries are popped into the
// expected active bank and the DUT outputs, BUSY and UPDATE_DONE are compared.
module tb_pwm_buffer_multi;

    localparam int WIDTH  = 13;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 3;
    localparam int BUS_W  = NUM_CH * WIDTH;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               MODE;
    logic [BUS_W-1:0]   CYCLE_M1;
    logic [BUS_W-1:0]   TIME_CNT;
    logic               WR_EN;
    logic [ADDR_W-1:0]  WR_ADDR;
    logic [WIDTH-1:0]   WR_RISE;
    logic [WIDTH-1:0]   WR_FALL;
    logic               COMMIT;
    logic [BUS_W-1:0]   RISE_OUT;
    logic [BUS_W-1:0]   FALL_OUT;
    logic               BUSY;
    logic               UPDATE_DONE;

    pwm_buffer_multi #(
        .WIDTH (WIDTH),
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MODE       (MODE),
        .CYCLE_M1   (CYCLE_M1),
        .TIME_CNT   (TIME_CNT),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_RISE    (WR_RISE),
        .WR_FALL    (WR_FALL),
        .COMMIT     (COMMIT),
        .RISE_OUT   (RISE_OUT),
        .FALL_OUT   (FALL_OUT),
        .BUSY       (BUSY),
        .UPDATE_DONE(UPDATE_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch;
        int due;
        int rise;
        int fall;
    } xfer_t;

    xfer_t sb[$];

    int cyc        [NUM_CH];
    int cnt        [NUM_CH];
    int sh_rise    [NUM_CH];
    int sh_fall    [NUM_CH];
    int exp_rise   [NUM_CH];
    int exp_fall   [NUM_CH];
    int pend_until [NUM_CH];
    int edge_n   = 0;
    int done_due = 0;
    int n_checks = 0;
    int n_fails  = 0;
    int saved_due;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic drive_cnt();
        for (int i = 0; i < NUM_CH; i++) begin
            CYCLE_M1[i*WIDTH +: WIDTH] = WIDTH'(cyc[i]);
            TIME_CNT[i*WIDTH +: WIDTH] = WIDTH'(cnt[i]);
        end
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            sh_rise[i]    = 0;
            sh_fall[i]    = 0;
            exp_rise[i]   = 0;
            exp_fall[i]   = 0;
            pend_until[i] = 0;
        end
        done_due = 0;
    endtask

    // Pop transfers due on the edge just taken, then compare everything.
    task automatic monitor();
        logic busy_exp;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].due == edge_n) begin
                exp_rise[sb[k].ch] = sb[k].rise;
                exp_fall[sb[k].ch] = sb[k].fall;
            end
        end
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due <= edge_n) sb.delete(k);
        end
        busy_exp = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_until[i] > edge_n) busy_exp = 1'b1;
            check($sformatf("rise_out[%0d]@edge%0d", i, edge_n), 32'(RISE_OUT[i*WIDTH +: WIDTH]), exp_rise[i]);
            check($sformatf("fall_out[%0d]@edge%0d", i, edge_n), 32'(FALL_OUT[i*WIDTH +: WIDTH]), exp_fall[i]);
        end
        check($sformatf("busy@edge%0d", edge_n), 32'(BUSY), 32'(busy_exp));
        check($sformatf("update_done@edge%0d", edge_n), 32'(UPDATE_DONE),
              32'((done_due != 0) && (edge_n == done_due)));
    endtask

    // One clock: inputs applied earlier are sampled, outputs checked at negedge,
    // pulses dropped and the free-running time counters advanced.
    task automatic cycle();
        @(posedge CLK);
        edge_n++;
        @(negedge CLK);
        monitor();
        WR_EN  = 1'b0;
        COMMIT = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] = (cnt[i] == cyc[i]) ? 0 : cnt[i] + 1;
        end
        drive_cnt();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic write(input int ch, input int r, input int f);
        WR_EN   = 1'b1;
        WR_ADDR = ADDR_W'(ch);
        WR_RISE = WIDTH'(r);
        WR_FALL = WIDTH'(f);
        if (ch < NUM_CH) begin
            sh_rise[ch] = r;
            sh_fall[ch] = f;
        end
        cycle();
    endtask

    // Stimulus never writes a pending channel between COMMIT and its boundary
    // except on the boundary edge itself, so the shadow seen now is the one transferred.
    task automatic commit(input logic mode);
        int    e;
        int    d;
        xfer_t t;
        e        = edge_n + 1;
        MODE     = mode;
        COMMIT   = 1'b1;
        done_due = 0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mode) begin
                t.due          = e;
                pend_until[ch] = 0;
            end else begin
                d = cyc[ch] - cnt[ch];
                if (d <= 0) d = cyc[ch] + 1;
                t.due          = e + d;
                pend_until[ch] = e + d;
                if (e + d > done_due) done_due = e + d;
            end
            t.ch   = ch;
            t.rise = clampv(sh_rise[ch], cyc[ch]);
            t.fall = clampv(sh_fall[ch], cyc[ch]);
            sb.push_back(t);
        end
        cycle();
        // Flip MODE while transfers are pending; they must still drain at boundaries.
        if (!mode) MODE = 1'b1;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (edge_n < done_due && guard < 9000) begin
            cycle();
            guard++;
        end
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N   = 1'b0;
        MODE    = 1'b0;
        WR_EN   = 1'b0;
        COMMIT  = 1'b0;
        WR_ADDR = '0;
        WR_RISE = '0;
        WR_FALL = '0;
        clear_model();
        cyc = '{1023, 2047, 4095, 4095};
        cnt = '{1000, 2000, 4000, 4070};
        drive_cnt();
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("reset_rise[%0d]", i), 32'(RISE_OUT[i*WIDTH +: WIDTH]), 0);
            check($sformatf("reset_fall[%0d]", i), 32'(FALL_OUT[i*WIDTH +: WIDTH]), 0);
        end
        check("reset_busy", 32'(BUSY), 0);
        check("reset_update_done", 32'(UPDATE_DONE), 0);
        run(2);
        RST_N = 1'b1;
        cycle();

        // Sync commit: each channel updates on its own boundary edge.
        for (int i = 0; i < NUM_CH; i++) write(i, 100 * (i + 1), 900);
        commit(1'b0);
        wait_idle();

        // Immediate commit: ch2 updates on the COMMIT edge, no BUSY, no done.
        write(2, 50, 60);
        commit(1'b1);
        run(3);

        // Clamp to the period, then widen the period and recommit the same shadow.
        cyc[1] = 1023;
        cnt[1] = 0;
        drive_cnt();
        write(1, 2000, 1500);
        commit(1'b0);
        wait_idle();
        cyc[1] = 4095;
        cnt[1] = 10;
        drive_cnt();
        commit(1'b1);
        run(2);

        // Collision: write ch0 on its own transfer edge; old shadow goes active.
        write(0, 55, 900);
        commit(1'b0);
        while (edge_n + 1 < pend_until[0]) cycle();
        write(0, 7, 900);
        wait_idle();
        commit(1'b0);
        wait_idle();

        // Out-of-range addresses must leave every shadow untouched.
        write(4, 1234, 1234);
        write(7, 4321, 4321);
        commit(1'b1);
        run(2);

        // Recommit after ch3 has transferred while the others are still pending.
        cnt = '{993, 4035, 4005, 4085};
        drive_cnt();
        commit(1'b0);
        while (edge_n < pend_until[3]) cycle();
        write(3, 444, 333);
        commit(1'b0);
        wait_idle();

        // Asynchronous reset with transfers pending.
        cnt = '{1000, 4060, 4070, 4050};
        drive_cnt();
        commit(1'b0);
        run(3);
        saved_due = done_due;
        #2;
        RST_N = 1'b0;
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("async_rst_rise[%0d]", i), 32'(RISE_OUT[i*WIDTH +: WIDTH]), 0);
            check($sformatf("async_rst_fall[%0d]", i), 32'(FALL_OUT[i*WIDTH +: WIDTH]), 0);
        end
        check("async_rst_busy", 32'(BUSY), 0);
        check("async_rst_update_done", 32'(UPDATE_DONE), 0);
        clear_model();
        run(2);
        RST_N = 1'b1;
        while (edge_n < saved_due + 2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
